csa: RTL and testbench

CSA -- requirements
Module: csa

---
 rtl/csa.sv | 63 ++++++
 tb/tb_csa.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/csa.sv
// Purpose: carry-save adder of three WIDTH-bit operands, then a final adder that resolves the carry vector.
// Latency: 1 cycle to Sum/Cout, 2 cycles to total; a new beat can be accepted every cycle.
// Backpressure: none; each valid beat flows straight through, and registers hold their value on idle cycles.
module csa #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] Cin,
  output logic [WIDTH-1:0] Sum,
  output logic [WIDTH-1:0] Cout,
  output logic             out_valid,
  output logic [WIDTH+1:0] total,
  output logic             total_valid
);

  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] c;
  logic [WIDTH+1:0] resolved;

  // Stage 1: per-bit full adders with no carry between bit positions
  always_comb begin
    s = A ^ B ^ Cin;
    c = (A & B) | (A & Cin) | (B & Cin);
  end

  // Stage 2: carry weights are one bit higher than sum weights, and WIDTH+2 bits cannot overflow
  always_comb begin
    resolved = {2'b00, Sum} + {1'b0, Cout, 1'b0};
  end

  // Stage-1 registers load only on valid beats; the valid flag follows every cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Sum       <= '0;
      Cout      <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        Sum  <= s;
        Cout <= c;
      end
    end
  end

  // Stage-2 register loads only when stage 1 holds a new result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      total       <= '0;
      total_valid <= 1'b0;
    end else begin
      total_valid <= out_valid;
      if (out_valid) begin
        total <= resolved;
      end
    end
  end

endmodule

// File: tb/tb_csa.sv
// Bench for csa: directed beats plus a random sweep on a 4-bit and a 16-bit instance.
// The stimulus pushes expected results into queues, and a monitor pops them and compares them on the falling edge.
// Also covers hold on idle cycles, asynchronous reset in mid-flight, and capture on the first edge after reset release.
module tb_csa;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [3:0]  a4 = '0, b4 = '0, c4 = '0;
  logic [15:0] a16 = '0, b16 = '0, c16 = '0;

  logic [3:0]  sum4, cout4;
  logic [5:0]  total4;
  logic        ov4, tv4;
  logic [15:0] sum16, cout16;
  logic [17:0] total16;
  logic        ov16, tv16;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]  q_s4[$];
  logic [5:0]  q_t4[$];
  logic [31:0] q_s16[$];
  logic [17:0] q_t16[$];

  always #5 clk = ~clk;

  csa #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .A(a4), .B(b4), .Cin(c4),
    .Sum(sum4), .Cout(cout4), .out_valid(ov4),
    .total(total4), .total_valid(tv4)
  );

  csa #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .A(a16), .B(b16), .Cin(c16),
    .Sum(sum16), .Cout(cout16), .out_valid(ov16),
    .total(total16), .total_valid(tv16)
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic stray(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: valid asserted with nothing expected (t=%0t)", nm, $time);
  endtask

  // Push expectations for one beat; the 16-bit model uses plain arithmetic at full width
  task automatic expect_beat(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                             input logic [3:0] es, input logic [3:0] ec, input logic [5:0] et,
                             input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
    logic [17:0] t16;
    q_s4.push_back({es, ec});
    q_t4.push_back(et);
    q_s16.push_back({x ^ y ^ z, (x & y) | (x & z) | (y & z)});
    t16 = 18'(x) + 18'(y) + 18'(z);
    q_t16.push_back(t16);
    a4 = a; b4 = b; c4 = c;
    a16 = x; b16 = y; c16 = z;
    in_valid = 1'b1;
  endtask

  task automatic beat(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                      input logic [3:0] es, input logic [3:0] ec, input logic [5:0] et);
    @(posedge clk); #1;
    expect_beat(a, b, c, es, ec, et, 16'($urandom), 16'($urandom), 16'($urandom));
  endtask

  task automatic rand_beat();
    logic [3:0] a, b, c;
    logic [5:0] t;
    a = 4'($urandom); b = 4'($urandom); c = 4'($urandom);
    t = 6'(a) + 6'(b) + 6'(c);
    beat(a, b, c, a ^ b ^ c, (a & b) | (a & c) | (b & c), t);
  endtask

  // Idle cycles carry garbage operands, which must not reach any output
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      a4 = 4'($urandom); b4 = 4'($urandom); c4 = 4'($urandom);
      a16 = 16'($urandom); b16 = 16'($urandom); c16 = 16'($urandom);
    end
  endtask

  task automatic flush();
    q_s4.delete(); q_t4.delete(); q_s16.delete(); q_t16.delete();
  endtask

  task automatic check_zero(input string tag);
    check({tag, " sum4"}, 64'(sum4), 64'd0);
    check({tag, " cout4"}, 64'(cout4), 64'd0);
    check({tag, " total4"}, 64'(total4), 64'd0);
    check({tag, " valids"}, 64'({ov4, tv4, ov16, tv16}), 64'd0);
    check({tag, " dut16"}, 64'({sum16, cout16, total16}), 64'd0);
  endtask

  // Monitor: pop and compare whenever a DUT presents a valid result
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (ov4) begin
          if (q_s4.size() == 0) stray("out_valid4");
          else check("stage1 w4 {Sum,Cout}", 64'({sum4, cout4}), 64'(q_s4.pop_front()));
        end
        if (tv4) begin
          if (q_t4.size() == 0) stray("total_valid4");
          else check("total w4", 64'(total4), 64'(q_t4.pop_front()));
        end
        if (ov16) begin
          if (q_s16.size() == 0) stray("out_valid16");
          else check("stage1 w16 {Sum,Cout}", 64'({sum16, cout16}), 64'(q_s16.pop_front()));
        end
        if (tv16) begin
          if (q_t16.size() == 0) stray("total_valid16");
          else check("total w16", 64'(total16), 64'(q_t16.pop_front()));
        end
      end
    end
  end

  initial begin
    int waited;
    #12;
    check_zero("reset");
    rst_n = 1'b1;

    // Directed vectors, back-to-back
    beat(4'b1011, 4'b1101, 4'b0110, 4'b0000, 4'b1111, 6'd30);
    beat(4'b1111, 4'b1111, 4'b0111, 4'b0111, 4'b1111, 6'd37);
    beat(4'b0001, 4'b0010, 4'b0001, 4'b0010, 4'b0001, 6'd4);
    beat(4'b0101, 4'b1010, 4'b0110, 4'b1001, 4'b0110, 6'd21);
    beat(4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 6'd45);
    idle(3);
    // Outputs hold the last beat across idle cycles with garbage inputs
    check("hold sum4", 64'(sum4), 64'hF);
    check("hold cout4", 64'(cout4), 64'hF);
    check("hold total4", 64'(total4), 64'd45);

    // Five beats back-to-back, then reset while the last beat is in flight
    for (int i = 0; i < 5; i++) rand_beat();
    @(posedge clk); #1;
    in_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    check_zero("mid-flight reset");
    flush();
    #10;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("no stray valid after reset", 64'({ov4, tv4, ov16, tv16}), 64'd0);
    end

    // A beat presented during reset is captured on the first edge after release
    #2;
    rst_n = 1'b0;
    #2;
    expect_beat(4'b0101, 4'b1010, 4'b0110, 4'b1001, 4'b0110, 6'd21,
                16'hFFFF, 16'hFFFF, 16'hFFFF);
    rst_n = 1'b1;
    idle(1);

    // Random sweep with random idle gaps
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) != 0) rand_beat();
      else idle(1);
    end
    idle(1);

    waited = 0;
    while ((q_s4.size() + q_t4.size() + q_s16.size() + q_t16.size()) != 0 && waited < 20) begin
      @(posedge clk);
      waited++;
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if ((q_s4.size() + q_t4.size() + q_s16.size() + q_t16.size()) != 0) begin
      n_bad++;
      $display("FAIL drain: %0d results still expected, required 0",
               q_s4.size() + q_t4.size() + q_s16.size() + q_t16.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
